mem_zeroize: RTL

Parametrised single-port word memory with byte-enable writes, registered reads and a built-in zeroization sequencer. It is the next-generation PMU scratch/key store: width and depth are parametrised, and contents can be erased on demand or automatically after reset. Secret material therefore never survives a reset or zeroize event. It sits between the PMU controller and its local storage and replaces the fixed 32x256 word memory.

---
 rtl/mem_zeroize_pkg.sv | 26 ++
 rtl/mem_zeroize_if.sv | 41 ++++
 rtl/mem_zeroize_bank.sv | 58 +++++
 rtl/mem_zeroize.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_zeroize_pkg.sv
// ---------------------------------------------------------------------------
// pmu_mem_pkg
// Shared definitions for the PMU scratch/key store (mem_zeroize).
//   - state_t        : sequencer state encoding (ST_CLEAR / ST_IDLE)
//   - PMU_MEM_DATA_W : default word width in bits
//   - PMU_MEM_ADDR_W : default address width in bits
//   - clrCntWidth()  : width of the sweep counter for a given depth
// ---------------------------------------------------------------------------
package pmu_mem_pkg;

  localparam int PMU_MEM_DATA_W = 32;
  localparam int PMU_MEM_ADDR_W = 8;

  // CLEAR is encoded as 1 so that the state bit itself reads as "busy".
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // One bit wider than needed to index DEPTH words, so the counter can
  // never wrap back onto a valid address without anyone noticing.
  function automatic int clrCntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_zeroize_if.sv
// ---------------------------------------------------------------------------
// mem_zeroize_if
// User-side access port of the PMU scratch/key store.
//   master (PMU controller) drives : req, we, be, addr, wdata, zeroize
//   slave  (mem_zeroize)    drives : rdata, rvalid, ready, busy, done, err
// clk/rst are not carried here; they stay plain module ports.
// ---------------------------------------------------------------------------
interface mem_zeroize_if
  import pmu_mem_pkg::*;
#(
  parameter int DATA_W = PMU_MEM_DATA_W,
  parameter int ADDR_W = PMU_MEM_ADDR_W
);

  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              zeroize;

  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req, we, be, addr, wdata, zeroize,
    input  rdata, rvalid, ready, busy, done, err
  );

  modport slave (
    input  req, we, be, addr, wdata, zeroize,
    output rdata, rvalid, ready, busy, done, err
  );

endinterface

// File: rtl/mem_zeroize_bank.sv
// ---------------------------------------------------------------------------
// mem_bank
// Raw single-port storage array with byte-enabled writes and a registered
// read port. Neither the array nor the read register is reset; clearing the
// contents is the job of the sequencer in mem_zeroize.
//   clk     : clock, rising edge
//   i_we    : write strobe
//   i_be    : byte enables, i_be[i] covers i_wdata[8i+7:8i]
//   i_addr  : word address (caller guarantees i_addr < DEPTH)
//   i_wdata : write data
//   i_re    : read strobe, loads o_rdata at the edge
//   o_rdata : registered read data, holds between reads
// ---------------------------------------------------------------------------
module mem_bank
  import pmu_mem_pkg::*;
#(
  parameter  int DATA_W = PMU_MEM_DATA_W,
  parameter  int ADDR_W = PMU_MEM_ADDR_W,
  parameter  int DEPTH  = 256,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [IDX_W-1:0]  w_idx;

  // Out-of-range addresses are filtered upstream, so only the low bits
  // are needed to pick a word.
  assign w_idx = i_addr[IDX_W-1:0];

  // Byte-lane writes plus the registered read. A read and a write never
  // arrive together from mem_zeroize, so read-during-write order is moot.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[w_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_zeroize.sv
// ---------------------------------------------------------------------------
// mem_zeroize
// PMU scratch/key store: parametrised word memory with byte-enable writes,
// 1-cycle registered reads and a zeroization sequencer. After reset, and
// whenever zeroize is sampled high, every word is overwritten with zero
// before user accesses are accepted again.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_zeroize_if.slave
//         req/we/be/addr/wdata : user access request
//         zeroize              : erase request, level-sampled
//         rdata/rvalid         : read result and its one-cycle strobe
//         ready/busy           : port accepting / sweep in progress
//         done/err             : sweep-complete and request-rejected pulses
// ---------------------------------------------------------------------------
module mem_zeroize
  import pmu_mem_pkg::*;
#(
  parameter  int DATA_W = PMU_MEM_DATA_W,
  parameter  int ADDR_W = PMU_MEM_ADDR_W,
  parameter  int DEPTH  = 256,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_zeroize_if.slave  bus
);

  localparam int                 CNT_W     = clrCntWidth(DEPTH);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]    DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_clrCnt;
  logic [CNT_W-1:0]  w_clrCntNext;
  logic              w_doneNext;
  logic              w_enterClear;

  logic              r_rdZero;
  logic              r_rvalid;
  logic              r_done;
  logic              r_err;

  logic              w_inRange;
  logic              w_accept;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic              w_reject;

  logic              w_bankWe;
  logic [BE_W-1:0]   w_bankBe;
  logic [ADDR_W-1:0] w_bankAddr;
  logic [DATA_W-1:0] w_bankWdata;
  logic              w_bankRe;
  logic [DATA_W-1:0] w_bankRdata;

  // Request qualification. The extra top bit on the address compare keeps
  // DEPTH == 2**ADDR_W representable, in which case every address is legal.
  always_comb begin
    w_inRange  = ({1'b0, bus.addr} < DEPTH_LIM);
    w_accept   = (r_state == ST_IDLE) & bus.req & ~bus.zeroize & w_inRange;
    w_wrAccept = w_accept & bus.we;
    w_rdAccept = w_accept & ~bus.we;
    w_reject   = bus.req & ~w_accept;
  end

  // Sequencer next state. A zeroize seen while already clearing restarts the
  // sweep from word 0 so the full DEPTH cycles are always spent after the
  // most recent request.
  always_comb begin
    w_stateNext  = r_state;
    w_clrCntNext = r_clrCnt;
    w_doneNext   = 1'b0;
    w_enterClear = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (bus.zeroize) begin
          w_clrCntNext = '0;
        end else if (r_clrCnt == LAST_IDX) begin
          w_stateNext  = ST_IDLE;
          w_clrCntNext = '0;
          w_doneNext   = 1'b1;
        end else begin
          w_clrCntNext = r_clrCnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.zeroize) begin
          w_stateNext  = ST_CLEAR;
          w_clrCntNext = '0;
          w_enterClear = 1'b1;
        end
      end
      default: begin
        w_stateNext  = ST_CLEAR;
        w_clrCntNext = '0;
      end
    endcase
  end

  // Storage port mux: the sweep owns the array while clearing and writes
  // whole zero words; otherwise only accepted user accesses reach it.
  always_comb begin
    w_bankWe    = 1'b0;
    w_bankBe    = '0;
    w_bankAddr  = '0;
    w_bankWdata = '0;
    w_bankRe    = 1'b0;
    if (r_state == ST_CLEAR) begin
      w_bankWe   = 1'b1;
      w_bankBe   = '1;
      w_bankAddr = ADDR_W'(r_clrCnt);
    end else begin
      w_bankWe    = w_wrAccept;
      w_bankBe    = bus.be;
      w_bankAddr  = bus.addr;
      w_bankWdata = bus.wdata;
      w_bankRe    = w_rdAccept;
    end
  end

  // State, counter and the single-cycle status pulses. The bank's read
  // register has no reset, so r_rdZero masks rdata to zero from reset or
  // zeroize entry until the next accepted read reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_clrCnt <= '0;
      r_rdZero <= 1'b1;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_clrCnt <= w_clrCntNext;
      r_rvalid <= w_rdAccept;
      r_done   <= w_doneNext;
      r_err    <= w_reject;
      if (w_enterClear) begin
        r_rdZero <= 1'b1;
      end else if (w_rdAccept) begin
        r_rdZero <= 1'b0;
      end
    end
  end

  mem_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_bankWe),
    .i_be    (w_bankBe),
    .i_addr  (w_bankAddr),
    .i_wdata (w_bankWdata),
    .i_re    (w_bankRe),
    .o_rdata (w_bankRdata)
  );

  assign bus.rdata  = r_rdZero ? '0 : w_bankRdata;
  assign bus.busy   = (r_state == ST_CLEAR);
  assign bus.ready  = (r_state != ST_CLEAR);
  assign bus.rvalid = r_rvalid;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule
